// File: rtl/hshrink_seq_if.sv
// hshrink_seq_if: request side, hshrink shifter side and line-buffer write side of hshrink_seq.
// The requester is the master; the sequencer is the slave.
interface hshrink_seq_if;
    // REQ/ACK: the requester raises REQ with SHRINK_IN/X_START/FLIP stable and holds all of them
    // until the cycle ACK is high; a transfer happens exactly in a cycle with REQ && ACK, and
    // ACK is never high without REQ.
    logic       LINE_START;
    logic       REQ;
    logic [3:0] SHRINK_IN;
    logic [8:0] X_START;
    logic       FLIP;
    logic       ACK;
    logic       BUSY;
    logic [3:0] HS_SHRINK;
    logic       HS_LOAD;
    logic       HS_OUTA;
    logic       HS_OUTB;
    logic       WE_A;
    logic       WE_B;
    logic [8:0] X_A;
    logic [8:0] X_B;
    logic [3:0] PIX_A;
    logic [3:0] PIX_B;
    logic       TILE_DONE;
    logic [4:0] TILE_W;

    modport master (
        output LINE_START, REQ, SHRINK_IN, X_START, FLIP, HS_OUTA, HS_OUTB,
        input  ACK, BUSY, HS_SHRINK, HS_LOAD, WE_A, WE_B, X_A, X_B, PIX_A, PIX_B,
        input  TILE_DONE, TILE_W
    );

    modport slave (
        input  LINE_START, REQ, SHRINK_IN, X_START, FLIP, HS_OUTA, HS_OUTB,
        output ACK, BUSY, HS_SHRINK, HS_LOAD, WE_A, WE_B, X_A, X_B, PIX_A, PIX_B,
        output TILE_DONE, TILE_W
    );
endinterface

// File: rtl/hshrink_seq.sv
// hshrink_seq: loads the hshrink keep shifter per tile row and turns its keep bits into line-buffer writes.
// Build macro HSHRINK_SEQ_FLIP_EN enables horizontal flip of the source pixel index.
module hshrink_seq #(
    parameter int unsigned X_VISIBLE = 320
) (
    input  logic         CK,
    input  logic         nRESET,
    hshrink_seq_if.slave bus,
    output logic [1:0]   DBG_STATE
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [9:0] XVIS = 10'(X_VISIBLE);

    state_t     state_q;
    logic       run_q;
    logic [2:0] k_q;
    logic [8:0] xc_q;
    logic [4:0] cnt_q;
    logic       busy_q;
    logic       hs_load_q;
    logic [3:0] hs_shrink_q;
    logic       we_a_q;
    logic       we_b_q;
    logic [8:0] x_a_q;
    logic [8:0] x_b_q;
    logic [3:0] pix_a_q;
    logic [3:0] pix_b_q;
    logic       done_q;
    logic [4:0] tile_w_q;

    logic       last_pair;
    logic       accept;
    logic [8:0] x_b_d;
    logic [8:0] xc_d;
    logic [4:0] kept_d;
    logic       vis_a;
    logic       vis_b;
    logic [3:0] pix_a_d;
    logic [3:0] pix_b_d;

`ifdef HSHRINK_SEQ_FLIP_EN
    logic       flip_q;
`else
    logic       unused_flip;
    assign unused_flip = bus.FLIP;
`endif

    always_comb begin
        last_pair = (state_q == S_RUN) && (k_q == 3'd7);
        // run_q holds off acceptance until the first edge after reset release.
        accept    = run_q && bus.REQ && !bus.LINE_START && ((state_q == S_IDLE) || last_pair);
        x_b_d     = bus.HS_OUTA ? xc_q + 9'd1 : xc_q;
        xc_d      = x_b_d + {8'd0, bus.HS_OUTB};
        kept_d    = {4'd0, bus.HS_OUTA} + {4'd0, bus.HS_OUTB};
        vis_a     = {1'b0, xc_q} < XVIS;
        vis_b     = {1'b0, x_b_d} < XVIS;
        pix_a_d   = {k_q, 1'b0};
        pix_b_d   = {k_q, 1'b1};
`ifdef HSHRINK_SEQ_FLIP_EN
        if (flip_q) begin
            pix_a_d = 4'd15 - {k_q, 1'b0};
            pix_b_d = 4'd15 - {k_q, 1'b1};
        end
`endif
    end

    always_ff @(posedge CK or negedge nRESET) begin
        if (!nRESET) begin
            state_q     <= S_IDLE;
            run_q       <= 1'b0;
            k_q         <= 3'd0;
            xc_q        <= 9'd0;
            cnt_q       <= 5'd0;
            busy_q      <= 1'b0;
            hs_load_q   <= 1'b0;
            hs_shrink_q <= 4'd0;
            we_a_q      <= 1'b0;
            we_b_q      <= 1'b0;
            x_a_q       <= 9'd0;
            x_b_q       <= 9'd0;
            pix_a_q     <= 4'd0;
            pix_b_q     <= 4'd0;
            done_q      <= 1'b0;
            tile_w_q    <= 5'd0;
`ifdef HSHRINK_SEQ_FLIP_EN
            flip_q      <= 1'b0;
`endif
        end else begin
            run_q       <= 1'b1;
            hs_load_q   <= 1'b0;
            hs_shrink_q <= 4'd0;
            we_a_q      <= 1'b0;
            we_b_q      <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                end
                S_LOAD: begin
                    state_q <= S_RUN;
                    busy_q  <= 1'b1;
                    k_q     <= 3'd0;
                    cnt_q   <= 5'd0;
                end
                S_RUN: begin
                    // Writes are issued even on an abort cycle so the sampled pair is not lost.
                    we_a_q  <= bus.HS_OUTA && vis_a;
                    we_b_q  <= bus.HS_OUTB && vis_b;
                    x_a_q   <= xc_q;
                    x_b_q   <= x_b_d;
                    pix_a_q <= pix_a_d;
                    pix_b_q <= pix_b_d;
                    xc_q    <= xc_d;
                    k_q     <= k_q + 3'd1;
                    cnt_q   <= cnt_q + kept_d;
                    if (last_pair) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        if (!bus.LINE_START) begin
                            done_q   <= 1'b1;
                            tile_w_q <= cnt_q + kept_d;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            if (accept) begin
                state_q     <= S_LOAD;
                busy_q      <= 1'b1;
                hs_load_q   <= 1'b1;
                hs_shrink_q <= bus.SHRINK_IN;
                xc_q        <= bus.X_START;
`ifdef HSHRINK_SEQ_FLIP_EN
                flip_q      <= bus.FLIP;
`endif
            end
            if (bus.LINE_START) begin
                state_q   <= S_IDLE;
                busy_q    <= 1'b0;
                hs_load_q <= 1'b0;
            end
        end
    end

    assign bus.ACK       = accept;
    assign bus.BUSY      = busy_q;
    assign bus.HS_SHRINK = hs_shrink_q;
    assign bus.HS_LOAD   = hs_load_q;
    assign bus.WE_A      = we_a_q;
    assign bus.WE_B      = we_b_q;
    assign bus.X_A       = x_a_q;
    assign bus.X_B       = x_b_q;
    assign bus.PIX_A     = pix_a_q;
    assign bus.PIX_B     = pix_b_q;
    assign bus.TILE_DONE = done_q;
    assign bus.TILE_W    = tile_w_q;
    assign DBG_STATE     = state_q;
endmodule
